// File: rtl/arm_pkg.sv
// arm_pkg: shared FSM state type and field widths for the ARM rotated-imm8 encoder
package arm_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  localparam int ROT_W = 4;
  localparam int IMM8_W = 8;
  localparam int SHIFT_OP_W = 12;
endpackage

// File: rtl/arm_rol32.sv
// arm_rol32: combinational 32-bit rotate left
module arm_rol32 (
  input  logic [31:0] data,
  input  logic [4:0]  amount,
  output logic [31:0] rotated
);
  logic [63:0] wide;
  assign wide = {data, data} << amount;
  assign rotated = wide[63:32];
endmodule

// File: rtl/arm_imm_encoder.sv
// arm_imm_encoder: serial search for the ARM rotated-imm8 encoding of a 32-bit constant
// Define ARM_IMM_ENCODER_MVN_EN to also try the complement (MVN) in parallel.
module arm_imm_encoder
  import arm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  encodable,
  output logic                  inverted,
  output logic [SHIFT_OP_W-1:0] shift_operand
);
  state_t state, next;
  logic [ROT_W-1:0] r;
  logic [31:0] val, rot_p;
  logic plain_hit, inv_hit, last;
  logic [IMM8_W-1:0] imm;
  arm_rol32 u_rol_p (.data(val), .amount({r, 1'b0}), .rotated(rot_p));
  assign plain_hit = rot_p[31:IMM8_W] == '0;
`ifdef ARM_IMM_ENCODER_MVN_EN
  logic [31:0] rot_n;
  arm_rol32 u_rol_n (.data(~val), .amount({r, 1'b0}), .rotated(rot_n));
  assign inv_hit = rot_n[31:IMM8_W] == '0;
  assign imm = plain_hit ? rot_p[IMM8_W-1:0] : rot_n[IMM8_W-1:0];
`else
  assign inv_hit = 1'b0;
  assign imm = rot_p[IMM8_W-1:0];
`endif
  assign last = r == {ROT_W{1'b1}};
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = in_valid ? SEARCH : IDLE;
      SEARCH:  next = (plain_hit || inv_hit || last) ? DONE : SEARCH;
      DONE:    next = out_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r <= '0;
      val <= '0;
      encodable <= 1'b0;
      inverted <= 1'b0;
      shift_operand <= '0;
    end else if (state == IDLE && in_valid) begin
      r <= '0;
      val <= value;
    end else if (state == SEARCH) begin
      if (plain_hit || inv_hit) begin
        shift_operand <= {r, imm};
        encodable <= 1'b1;
        inverted <= !plain_hit;
      end else if (last) begin
        shift_operand <= '0;
        encodable <= 1'b0;
        inverted <= 1'b0;
      end else r <= r + 1'b1;
    end
endmodule

// File: tb/tb_arm_imm_encoder.sv
// tb_arm_imm_encoder: scoreboard bench with directed vectors for arm_imm_encoder
module tb_arm_imm_encoder;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 1;
  logic [31:0] value = 0;
  logic in_ready, out_valid, encodable, inverted;
  logic [11:0] shift_operand;
  typedef struct {logic [11:0] so; logic enc; logic inv; int lat; int acc;} exp_t;
  exp_t q[$];
  int cyc = 0, passed = 0, total = 0;
  bit seen = 0;

  arm_imm_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .value(value),
    .out_valid(out_valid), .out_ready(out_ready), .encodable(encodable),
    .inverted(inverted), .shift_operand(shift_operand)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) seen = 0;
    else if (out_valid && !seen) begin
      seen = 1;
      if (q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = q.pop_front();
        chk("shift_operand", {20'd0, shift_operand}, {20'd0, e.so});
        chk("encodable", {31'd0, encodable}, {31'd0, e.enc});
        chk("inverted", {31'd0, inverted}, {31'd0, e.inv});
        chk("latency", cyc - e.acc, e.lat);
      end
    end else if (!out_valid) seen = 0;
  end

  task automatic send(input logic [31:0] v, input logic [11:0] so, input logic enc,
                      input logic inv, input int lat);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1;
    value = v;
    @(posedge clk);
    #1;
    in_valid = 0;
    e.so = so; e.enc = enc; e.inv = inv; e.lat = lat; e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (q.size() != 0) begin chk("drain_timeout", q.size(), 0); q.delete(); end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_shift_operand", {20'd0, shift_operand}, 0);
    rst = 1;
    send(32'h000000FF, 12'h0FF, 1, 0, 1);
    send(32'hFF000000, 12'h4FF, 1, 0, 5);
    send(32'h000003FC, 12'hFFF, 1, 0, 16);
    send(32'h00000101, 12'h000, 0, 0, 16);
    send(32'h00000000, 12'h000, 1, 0, 1);
    send(32'hC000003F, 12'h1FF, 1, 0, 2);
    send(32'h00AB0000, 12'h8AB, 1, 0, 9);
`ifdef ARM_IMM_ENCODER_MVN_EN
    send(32'hFFFFFF00, 12'h0FF, 1, 1, 1);
`else
    send(32'hFFFFFF00, 12'h000, 0, 0, 16);
`endif
    drain();
    // back-pressure: result must hold and a new request must be ignored
    out_ready = 0;
    send(32'hFF000000, 12'h4FF, 1, 0, 5);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin in_valid = 1; value = 32'h00000001; end
      if (i == 4) in_valid = 0;
      chk("bp_out_valid", {31'd0, out_valid}, 1);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      chk("bp_shift_operand", {20'd0, shift_operand}, 32'h4FF);
      chk("bp_encodable", {31'd0, encodable}, 1);
    end
    out_ready = 1;
    drain();
    repeat (3) @(negedge clk);
    chk("bp_idle_after", {31'd0, in_ready}, 1);
    // reset in the middle of an unencodable search
    send(32'h00000101, 12'h000, 0, 0, 16);
    repeat (3) @(posedge clk);
    #2 rst = 0;
    q.delete();
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
    chk("mid_rst_encodable", {31'd0, encodable}, 0);
    chk("mid_rst_inverted", {31'd0, inverted}, 0);
    chk("mid_rst_shift_operand", {20'd0, shift_operand}, 0);
    @(negedge clk);
    rst = 1;
    send(32'h000000FF, 12'h0FF, 1, 0, 1);
    drain();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/arm_imm_encoder.md
ARM_IMM_ENCODER -- requirements
Module: arm_imm_encoder

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- in_valid  input  1  request carries a 32-bit constant
- in_ready  output  1  block can accept a request
- value  input  32  constant to encode
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- encodable  output  1  value (or its complement, see REQ-019) fits the ARM rotated-imm8 form
- inverted  output  1  encoding is of ~value
- shift_operand  output  12  {rotate_imm[3:0], imm8[7:0]}; ROR(imm8, 2*rotate_imm) equals the encoded constant
REQ-002 The reset SHALL be named rst, asynchronous, active-low; there SHALL be one clock, clk.

Function
REQ-003 The FSM SHALL have states IDLE, SEARCH and DONE.
REQ-004 in_ready SHALL be 1 only in IDLE.
REQ-005 A request SHALL be accepted on a rising edge with in_valid && in_ready; value SHALL be latched into an internal register; state SHALL go to SEARCH with rotation counter r = 0.
REQ-006 In each SEARCH cycle, candidate SHALL be ROL(latched value, 2*r) (32-bit rotate, no loss of bits).
- Hit: candidate[31:8] == 0.
REQ-007 On a hit: shift_operand <= {r, candidate[7:0]}, encodable <= 1, state <= DONE.
REQ-008 On a miss with r < 15: r SHALL increment.
REQ-009 On a miss with r == 15: encodable <= 0, shift_operand <= 0, state <= DONE.
REQ-010 The smallest matching r SHALL be reported.
- Search SHALL terminate early on the first hit.
REQ-011 Latency: out_valid SHALL rise r+1 clock edges after the accepting edge for a hit at rotation r; unencodable values SHALL take 16 edges.
REQ-012 In DONE, out_valid SHALL be 1, and encodable, inverted and shift_operand SHALL be held stable until out_valid && out_ready.
REQ-013 On the edge with out_valid && out_ready, state SHALL go to IDLE; out_valid SHALL drop.
- A new request SHALL NOT be accepted on that same edge; minimum request spacing is latency + 2 cycles.
REQ-014 Changes on value/in_valid during SEARCH or DONE SHALL have no effect.
REQ-015 value == 0 SHALL encode as shift_operand = 0x000, encodable = 1, at r = 0.

Reset
REQ-016 Assertion of rst SHALL force, at any time including mid-SEARCH or DONE: state = IDLE, r = 0, latched value = 0, out_valid = 0, encodable = 0, inverted = 0, shift_operand = 0, in_ready = 1.
REQ-017 After rst deasserts, the first request SHALL be accepted no earlier than the first clk edge.
- No partial result of an aborted search SHALL ever appear on the outputs.

Configuration
REQ-018 Macro ARM_IMM_ENCODER_MVN_EN SHALL select MVN/complement support.
REQ-019 With ARM_IMM_ENCODER_MVN_EN defined, each SEARCH cycle SHALL test ROL(value, 2*r) and ROL(~value, 2*r) in parallel.
- Plain hit takes priority (inverted = 0).
- Otherwise a complement hit sets inverted = 1 and encodes the complement.
- Latency rules of REQ-011 apply to the first r where either test hits.
REQ-020 Without the macro, only the plain test SHALL exist and inverted SHALL be constant 0; the port SHALL remain present.

Structure
REQ-021 Shared package arm_pkg SHALL hold:
- The FSM state enum (IDLE/SEARCH/DONE).
- ROT_W = 4, IMM8_W = 8 and SHIFT_OP_W = 12.
REQ-022 The 32-bit left rotator SHALL be a combinational sub-module arm_rol32 (inputs data[31:0] and amount[4:0]; output data rotated left), instantiated once, or twice with the macro.

Verification
REQ-023 value = 0x000000FF -> shift_operand = 0x0FF, encodable = 1, inverted = 0, out_valid 1 edge after accept.
REQ-024 value = 0xFF000000 -> shift_operand = 0x4FF, encodable = 1, out_valid 5 edges after accept.
REQ-025 value = 0x000003FC -> shift_operand = 0xFFF, encodable = 1, 16 edges; value = 0x00000101 -> encodable = 0, shift_operand = 0x000, 16 edges (both builds).
REQ-026 value = 0xFFFFFF00 -> with ARM_IMM_ENCODER_MVN_EN: encodable = 1, inverted = 1, shift_operand = 0x0FF after 1 edge; without: encodable = 0 after 16 edges.
REQ-027 Back-pressure: hold out_ready = 0 for 10 cycles in DONE -> outputs stable and in_ready = 0 throughout; pulse in_valid with a new value meanwhile -> ignored.
REQ-028 Reset mid-search: assert rst 3 cycles into the search for 0x00000101 -> all outputs 0 immediately with in_ready = 1; next request 0x000000FF completes normally.
